// File: rtl/data_break_arbiter.sv
// PDP-8e data-break (DMA) arbiter: fixed-priority selection among NDEV devices,
// performing one single-cycle or three-cycle (WC/CA/B) break per CPU grant.
module data_break_arbiter #(
    parameter int unsigned NDEV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NDEV-1:0]    dev_req,
    input  logic [NDEV-1:0]    dev_three_cycle,
    input  logic [NDEV-1:0]    dev_to_mem,
    input  logic [0:15*NDEV-1] dev_addr,
    input  logic [0:12*NDEV-1] dev_wc_addr,
    input  logic [0:3*NDEV-1]  dev_field,
    input  logic [0:12*NDEV-1] dev_wdata,
    input  logic               break_grant,
    input  logic [0:11]        mem_rdata,
    output logic               data_break,
    output logic [0:14]        mem_addr,
    output logic [0:11]        mem_wdata,
    output logic               mem_we,
    output logic [NDEV-1:0]    dev_ack,
    output logic [0:11]        dev_rdata,
    output logic [NDEV-1:0]    dev_wc_ovf,
    output logic               busy
);

    localparam int unsigned SELW = (NDEV > 1) ? $clog2(NDEV) : 1;

    typedef enum logic [3:0] {
        IDLE, REQ, WC_RD, WC_WR, CA_RD, CA_WR, B_ADDR, B_CAP, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            three_q, three_d;
    logic            to_mem_q, to_mem_d;
    logic [14:0]     addr_q, addr_d;
    logic [11:0]     wc_q, wc_d;
    logic [2:0]      field_q, field_d;
    logic [11:0]     wdata_q, wdata_d;
    logic [11:0]     ca_q, ca_d;
    logic [11:0]     rdata_q, rdata_d;
    logic            ovf_q, ovf_d;

    logic            win_found;
    logic [SELW-1:0] win_idx;
    logic            win_three;
    logic            win_to_mem;
    logic [14:0]     win_addr;
    logic [11:0]     win_wc;
    logic [2:0]      win_field;
    logic [11:0]     win_wdata;

    logic [11:0]     rd_inc;
    logic [11:0]     ca_loc;
    logic [14:0]     b_addr;

    // Lowest asserted index wins; its request fields are gathered for latching.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_three  = 1'b0;
        win_to_mem = 1'b0;
        win_addr   = '0;
        win_wc     = '0;
        win_field  = '0;
        win_wdata  = '0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            if (!win_found && dev_req[i]) begin
                win_found  = 1'b1;
                win_idx    = SELW'(i);
                win_three  = dev_three_cycle[i];
                win_to_mem = dev_to_mem[i];
                win_addr   = dev_addr[15*i +: 15];
                win_wc     = dev_wc_addr[12*i +: 12];
                win_field  = dev_field[3*i +: 3];
                win_wdata  = dev_wdata[12*i +: 12];
            end
        end
    end

    assign rd_inc    = mem_rdata + 12'd1;
    assign ca_loc    = wc_q + 12'd1;
    assign b_addr    = three_q ? {field_q, ca_q} : addr_q;
    assign busy      = (state_q != IDLE);
    assign dev_rdata = rdata_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        three_d    = three_q;
        to_mem_d   = to_mem_q;
        addr_d     = addr_q;
        wc_d       = wc_q;
        field_d    = field_q;
        wdata_d    = wdata_q;
        ca_d       = ca_q;
        rdata_d    = rdata_q;
        ovf_d      = ovf_q;
        data_break = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        dev_ack    = '0;
        dev_wc_ovf = '0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = REQ;
                    sel_d    = win_idx;
                    three_d  = win_three;
                    to_mem_d = win_to_mem;
                    addr_d   = win_addr;
                    wc_d     = win_wc;
                    field_d  = win_field;
                    wdata_d  = win_wdata;
                    ovf_d    = 1'b0;
                end
            end
            REQ: begin
                data_break = 1'b1;
                if (break_grant) begin
                    state_d = three_q ? WC_RD : B_ADDR;
                end
            end
            WC_RD: begin
                data_break = 1'b1;
                mem_addr   = {3'o0, wc_q};
                state_d    = WC_WR;
            end
            WC_WR: begin
                data_break = 1'b1;
                mem_addr   = {3'o0, wc_q};
                mem_wdata  = rd_inc;
                mem_we     = 1'b1;
                ovf_d      = (rd_inc == 12'd0);
                state_d    = CA_RD;
            end
            CA_RD: begin
                data_break = 1'b1;
                mem_addr   = {3'o0, ca_loc};
                state_d    = CA_WR;
            end
            CA_WR: begin
                data_break = 1'b1;
                mem_addr   = {3'o0, ca_loc};
                mem_wdata  = rd_inc;
                mem_we     = 1'b1;
                ca_d       = rd_inc;
                state_d    = B_ADDR;
            end
            B_ADDR: begin
                data_break = 1'b1;
                mem_addr   = b_addr;
                if (to_mem_q) begin
                    mem_wdata = wdata_q;
                    mem_we    = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d   = B_CAP;
                end
            end
            B_CAP: begin
                // RAM data for the address presented in B_ADDR arrives here.
                data_break = 1'b1;
                mem_addr   = b_addr;
                rdata_d    = mem_rdata;
                state_d    = DONE;
            end
            DONE: begin
                dev_ack[sel_q]    = 1'b1;
                dev_wc_ovf[sel_q] = ovf_q;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            three_q  <= 1'b0;
            to_mem_q <= 1'b0;
            addr_q   <= '0;
            wc_q     <= '0;
            field_q  <= '0;
            wdata_q  <= '0;
            ca_q     <= '0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            three_q  <= three_d;
            to_mem_q <= to_mem_d;
            addr_q   <= addr_d;
            wc_q     <= wc_d;
            field_q  <= field_d;
            wdata_q  <= wdata_d;
            ca_q     <= ca_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_data_break_arbiter.sv
// Bench for data_break_arbiter: synchronous RAM model, shadow-memory reference
// model of each break, directed boundary cases and randomized request rounds.
module tb_data_break_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  dev_req;
    logic [3:0]  dev_three_cycle;
    logic [3:0]  dev_to_mem;
    logic [0:59] dev_addr;
    logic [0:47] dev_wc_addr;
    logic [0:11] dev_field;
    logic [0:47] dev_wdata;
    logic        break_grant;
    logic [0:11] mem_rdata;
    logic        data_break;
    logic [0:14] mem_addr;
    logic [0:11] mem_wdata;
    logic        mem_we;
    logic [3:0]  dev_ack;
    logic [0:11] dev_rdata;
    logic [3:0]  dev_wc_ovf;
    logic        busy;

    logic [11:0] ram    [0:32767];
    logic [11:0] shadow [0:32767];
    logic        sync_req;

    logic        d_three [4];
    logic        d_tomem [4];
    logic [14:0] d_addr  [4];
    logic [11:0] d_wc    [4];
    logic [2:0]  d_field [4];
    logic [11:0] d_wdata [4];

    int checks   = 0;
    int failures = 0;

    data_break_arbiter #(.NDEV(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .dev_req         (dev_req),
        .dev_three_cycle (dev_three_cycle),
        .dev_to_mem      (dev_to_mem),
        .dev_addr        (dev_addr),
        .dev_wc_addr     (dev_wc_addr),
        .dev_field       (dev_field),
        .dev_wdata       (dev_wdata),
        .break_grant     (break_grant),
        .mem_rdata       (mem_rdata),
        .data_break      (data_break),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .dev_ack         (dev_ack),
        .dev_rdata       (dev_rdata),
        .dev_wc_ovf      (dev_wc_ovf),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dev_three_cycle[i]      = d_three[i];
            dev_to_mem[i]           = d_tomem[i];
            dev_addr[15*i +: 15]    = d_addr[i];
            dev_wc_addr[12*i +: 12] = d_wc[i];
            dev_field[3*i +: 3]     = d_field[i];
            dev_wdata[12*i +: 12]   = d_wdata[i];
        end
    end

    // Synchronous RAM; sync_req copies the shadow image in while the DUT is idle.
    always @(posedge clk) begin
        if (sync_req) begin
            for (int a = 0; a < 32768; a++) ram[a] <= shadow[a];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sync_mem();
        sync_req = 1'b1;
        @(negedge clk);
        sync_req = 1'b0;
    endtask

    task automatic rand_dev(input int i);
        d_three[i] = 1'($urandom_range(0, 1));
        d_tomem[i] = 1'($urandom_range(0, 1));
        d_addr[i]  = 15'($urandom);
        d_wc[i]    = 12'($urandom);
        d_field[i] = 3'($urandom);
        d_wdata[i] = 12'($urandom);
    endtask

    task automatic wait_db(input string tag);
        int n;
        n = 0;
        while (data_break !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, data_break, 1);
    endtask

    // One break for device d: predict effects on the shadow memory, grant after
    // gdelay clocks, then check latency, ack/ovf pulses, data and RAM image.
    task automatic run_break(input int d, input int gdelay, input int drop_at);
        logic [11:0] wc, ca, caloc, rd, wdata_seen;
        logic [14:0] baddr, waddr_seen;
        logic        ovf;
        int          exp_writes, exp_lat, lat, writes, db_low, mism;
        bit          got;

        ovf        = 1'b0;
        rd         = '0;
        exp_writes = 0;
        if (d_three[d]) begin
            wc = shadow[{3'o0, d_wc[d]}] + 12'd1;
            shadow[{3'o0, d_wc[d]}] = wc;
            ovf   = (wc == 12'd0);
            caloc = d_wc[d] + 12'd1;
            ca    = shadow[{3'o0, caloc}] + 12'd1;
            shadow[{3'o0, caloc}] = ca;
            baddr = {d_field[d], ca};
            exp_writes = 2;
        end else begin
            baddr = d_addr[d];
        end
        if (d_tomem[d]) begin
            shadow[baddr] = d_wdata[d];
            exp_writes++;
        end else begin
            rd = shadow[baddr];
        end
        exp_lat = 2 + (d_three[d] ? 4 : 0) + (d_tomem[d] ? 0 : 1);

        wait_db("data_break_raised");
        repeat (gdelay) @(negedge clk);
        break_grant = 1'b1;
        got = 1'b0; lat = -1; writes = 0; db_low = 0;
        waddr_seen = '0; wdata_seen = '0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (k == drop_at) dev_req[d] = 1'b0;
            if (mem_we) begin
                writes++;
                waddr_seen = mem_addr;
                wdata_seen = mem_wdata;
            end
            if (dev_ack != 4'b0) begin
                got = 1'b1;
                lat = k;
            end else if (!data_break) begin
                db_low++;
            end
        end
        chk("ack_latency", lat, exp_lat);
        chk("ack_onehot", dev_ack, 64'd1 << d);
        chk("wc_ovf", dev_wc_ovf, 64'(ovf) << d);
        chk("data_break_done", data_break, 0);
        chk("data_break_held", db_low, 0);
        chk("write_count", writes, exp_writes);
        if (d_tomem[d]) begin
            chk("b_waddr", waddr_seen, baddr);
            chk("b_wdata", wdata_seen, d_wdata[d]);
        end else begin
            chk("b_rdata", dev_rdata, rd);
        end
        break_grant = 1'b0;
        dev_req[d]  = 1'b0;
        @(negedge clk);
        chk("ack_one_clock", dev_ack, 0);
        chk("idle_after_done", {busy, data_break}, 0);
        mism = 0;
        for (int a = 0; a < 32768; a++) if (ram[a] !== shadow[a]) mism++;
        chk("mem_image", mism, 0);
    endtask

    initial begin
        int w;
        int win;

        reset       = 1'b0;
        break_grant = 1'b0;
        dev_req     = 4'b0;
        sync_req    = 1'b0;
        for (int i = 0; i < 4; i++) rand_dev(i);
        for (int a = 0; a < 32768; a++) shadow[a] = 12'($urandom);
        sync_mem();
        repeat (2) @(negedge clk);
        chk("reset_outputs", {data_break, mem_addr, mem_wdata, mem_we, dev_ack,
                              dev_rdata, dev_wc_ovf, busy}, 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: reset asserted in the middle of WC_WR
        d_three[0] = 1'b1; d_tomem[0] = 1'b0; d_wc[0] = 12'o0100; d_field[0] = 3'd1;
        shadow[15'o00100] = 12'o7776;
        sync_mem();
        dev_req = 4'b0001;
        wait_db("t1_data_break");
        break_grant = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t1_wcwr_we", mem_we, 1);
        chk("t1_wcwr_wdata", mem_wdata, 12'o7777);
        #1 reset = 1'b0; dev_req = 4'b0; break_grant = 1'b0;
        #1 chk("t1_reset_outputs", {data_break, mem_addr, mem_wdata, mem_we, dev_ack,
                                    dev_rdata, dev_wc_ovf, busy}, 0);
        w = 0;
        repeat (3) begin @(negedge clk); if (mem_we) w++; end
        reset = 1'b1;
        repeat (4) begin @(negedge clk); if (mem_we) w++; end
        chk("t1_no_later_write", w, 0);
        chk("t1_idle", {busy, data_break}, 0);
        chk("t1_wc_loc", (ram[15'o00100] == 12'o7776) || (ram[15'o00100] == 12'o7777), 1);
        shadow[15'o00100] = ram[15'o00100];

        // 2: dev 1 single-cycle write, grant three clocks after data_break
        d_three[1] = 1'b0; d_tomem[1] = 1'b1; d_addr[1] = 15'o12345; d_wdata[1] = 12'o4321;
        dev_req = 4'b0010;
        run_break(1, 3, 0);
        chk("t2_ram", ram[15'o12345], 12'o4321);

        // 3: dev 0 three-cycle read with WC overflow
        d_three[0] = 1'b1; d_tomem[0] = 1'b0; d_wc[0] = 12'o0030; d_field[0] = 3'd2;
        shadow[15'o00030] = 12'o7777;
        shadow[15'o00031] = 12'o0177;
        shadow[15'o20200] = 12'o1234;
        sync_mem();
        dev_req = 4'b0001;
        run_break(0, 1, 0);
        chk("t3_wc", ram[15'o00030], 12'o0000);
        chk("t3_ca", ram[15'o00031], 12'o0200);
        chk("t3_rdata", dev_rdata, 12'o1234);

        // 4: simultaneous requests, lowest index first, no preemption
        rand_dev(0); rand_dev(2);
        dev_req = 4'b0101;
        run_break(0, 1, 0);
        chk("t4_dev2_pending", dev_req, 4'b0100);
        run_break(2, 2, 0);

        // 5: WC at 7777 so CA wraps to 0000 within field 0
        d_three[3] = 1'b1; d_tomem[3] = 1'b1; d_wc[3] = 12'o7777; d_field[3] = 3'd5;
        d_wdata[3] = 12'o6543;
        shadow[15'o07777] = 12'o0005;
        shadow[15'o00000] = 12'o0010;
        sync_mem();
        dev_req = 4'b1000;
        run_break(3, 0, 0);
        chk("t5_wc", ram[15'o07777], 12'o0006);
        chk("t5_ca", ram[15'o00000], 12'o0011);
        chk("t5_b", ram[15'o50011], 12'o6543);

        // 6: request withdrawn during WC_RD still completes
        rand_dev(0);
        d_three[0] = 1'b1;
        dev_req = 4'b0001;
        run_break(0, 0, 1);

        // randomized rounds: all pending requests served in priority order
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) rand_dev(i);
            dev_req = 4'($urandom_range(1, 15));
            for (int guard = 0; guard < 4 && dev_req != 4'b0; guard++) begin
                win = -1;
                for (int i = 3; i >= 0; i--) if (dev_req[i]) win = i;
                run_break(win, int'($urandom_range(0, 3)), 0);
            end
            chk("rand_all_served", dev_req, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_break_arbiter.md
Name: data_break_arbiter

Overview:
- Arbitrates the PDP-8e memory between the CPU state machine and up to NDEV data-break (DMA) devices, such as the disk controller.
- Raises `data_break` to the state machine and waits for `break_grant` at a major-cycle boundary.
- Executes one single-cycle or three-cycle (WC/CA/B) break for the highest-priority requester, then hands memory back.

Parameters:
- NDEV, 4, number of break requesters; index 0 is highest priority.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- dev_req  in  NDEV  break request per device; held until dev_ack.
- dev_three_cycle  in  NDEV  1 = three-cycle break, 0 = single-cycle break.
- dev_to_mem  in  NDEV  1 = write device data to memory, 0 = read memory to device.
- dev_addr  in  15*NDEV  single-cycle address; device i uses bits 15i..15i+14, MSB first (bit 0 = MSB convention).
- dev_wc_addr  in  12*NDEV  field-0 word-count location; CA is at WC+1.
- dev_field  in  3*NDEV  data field for three-cycle transfers.
- dev_wdata  in  12*NDEV  data to memory.
- break_grant  in  1  from state_machine: CPU is at a break-eligible cycle boundary.
- mem_rdata  in  [0:11]  RAM read data, valid one clock after address.
- data_break  out  1  request to state_machine.
- mem_addr  out  [0:14]  RAM address.
- mem_wdata  out  [0:11]  RAM write data.
- mem_we  out  1  RAM write enable.
- dev_ack  out  NDEV  one-clock one-hot completion pulse.
- dev_rdata  out  [0:11]  data read for the acked device; valid with dev_ack.
- dev_wc_ovf  out  NDEV  one-clock pulse with dev_ack when the incremented WC == 0.
- busy  out  1  break in progress (IDLE excluded).

Behaviour:
Reset (reset=0, async):
- State goes to IDLE.
- All outputs go to 0; latched selection is cleared.
- Reset mid-break abandons the cycle with no further writes.

States:
- IDLE
  - Any dev_req → REQ.
  - Latch winner: lowest-index asserted bit.
  - Latch that device's three_cycle, to_mem, addr, wc_addr, field and wdata.
- REQ
  - data_break=1.
  - Hold until break_grant=1.
  - Then → WC_RD if three_cycle, else → B_ADDR.
- WC_RD
  - mem_addr = {3'o0, wc_addr}, mem_we=0.
- WC_WR
  - mem_addr unchanged, mem_wdata = mem_rdata+1 (mod 4096), mem_we=1.
  - Set ovf flag if result is 0.
- CA_RD
  - mem_addr = {3'o0, wc_addr+1}; the +1 wraps 7777→0000 within field 0.
- CA_WR
  - mem_wdata = mem_rdata+1 (mod 4096), mem_we=1.
  - Latch ca = incremented value.
- B_ADDR
  - mem_addr = three_cycle ? {field, ca} : addr.
  - If to_mem: mem_wdata=wdata, mem_we=1, → DONE.
  - Else mem_we=0, → B_CAP.
- B_CAP
  - Capture dev_rdata = mem_rdata, → DONE.
- DONE
  - dev_ack[sel]=1 and dev_wc_ovf[sel]=ovf, for one clock.
  - data_break drops this cycle.
  - → IDLE.

data_break timing:
- data_break=1 from entry to REQ through the last state before DONE.
- The state machine must not access memory while data_break && break_grant.

Latency, from grant to ack:
- Single-cycle write: 2 clocks.
- Single-cycle read: 3 clocks.
- Three-cycle write: 6 clocks.
- Three-cycle read: 7 clocks.

Boundary conditions:
- A dev_req drop after latching is ignored; the break completes.
- A new higher-priority request during a break waits for IDLE; there is no preemption.
- A re-asserted request is re-arbitrated from IDLE, one clock after DONE at the earliest.
- Simultaneous requests: the lowest index wins. Others stay pending, each served on a later grant.
- break_grant low in any state other than REQ is ignored.
- mem_we is high only in WC_WR, CA_WR and B_ADDR(to_mem).

Test Plan:
1. Reset low mid-WC_WR, with the WC location preloaded to 7776.
   - All outputs 0, state IDLE.
   - WC location is read back as 7776, or 7777 if the write clock already occurred.
   - No later write occurs.
2. Dev 1 single-cycle write: addr=15'o12345, wdata=12'o4321, break_grant after 3 clocks.
   - data_break high.
   - mem_we pulse at 12345 with 4321.
   - dev_ack=0010 two clocks after grant.
3. Dev 0 three-cycle read: WC loc 0030=7777, 0031=0177, field=2, mem 20200=1234.
   - 0030 becomes 0000, 0031 becomes 0200.
   - dev_rdata=1234.
   - dev_ack[0] and dev_wc_ovf[0] pulse together, seven clocks after grant.
4. dev_req=0101 simultaneously.
   - Dev 0 is acked first.
   - Dev 2 is acked after a second grant.
   - Dev 2 is never acked while dev 0 is busy.
5. Three-cycle with wc_addr=7777: CA is read and written at 0000.
   - Second location 7777 is unchanged except the WC increment at 7777.
6. Dev 0 drops dev_req in WC_RD.
   - The break still completes.
   - dev_ack[0] pulses.
   - Then IDLE with data_break=0.
